min_scan_unit: RTL and testbench
================================

MIN_SCAN_UNIT -- requirements
Module: min_scan_unit

Interface
REQ-001 SHALL have parameter SIZE, default 8, meaning sample width in bits (two's-complement signed).
REQ-002 SHALL have parameter COUNT, default 16, meaning samples per scan (COUNT >= 2).
REQ-003 SHALL have the parameter-derived width IW = $clog2(COUNT), used for the index port and the sample counter.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  begin a scan; sampled only in IDLE.
REQ-007 SHALL have port in_valid  input  1  in_data holds a sample.
REQ-008 SHALL have port in_data  input  SIZE  signed sample.
REQ-009 SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-010 SHALL have port busy  output  1  scan in progress (INIT or SCAN).
REQ-011 SHALL have port done  output  1  one-cycle pulse: result valid.
REQ-012 SHALL have port min_out  output  SIZE  running/final minimum (registered).
REQ-013 SHALL have port min_idx  output  IW  index of the minimum within the scan (registered).

Function
REQ-014 SHALL implement FSM states IDLE, INIT, SCAN, DONE.
REQ-015 SHALL, in IDLE with start=1, move to INIT on the next edge; start=0 keeps IDLE.
REQ-016 SHALL, in INIT (exactly one cycle), load min_out with the maximum positive value {1'b0, {SIZE-1{1'b1}}} and clear min_idx and the sample counter to 0, then enter SCAN.
REQ-017 SHALL drive in_ready=1 only in SCAN; in_ready is 0 in IDLE, INIT and DONE.
REQ-018 SHALL accept a sample on any edge with in_valid=1 and in_ready=1; in_valid=0 stalls the scan with no state change.
REQ-019 SHALL, on acceptance, compare in_data < min_out as signed values; if true, load min_out<=in_data and min_idx<=counter on the same edge.
REQ-020 SHALL keep min_out and min_idx unchanged on a tie, so the earliest index of equal minima wins.
REQ-021 SHALL increment the counter by 1 per accepted sample.
REQ-022 SHALL, on acceptance of the sample with counter = COUNT-1, enter DONE; the counter does not wrap within a scan.
REQ-023 SHALL assert done=1 for exactly the one DONE cycle, then return to IDLE.
REQ-024 SHALL make min_out and min_idx final in the DONE cycle and hold them until the next INIT.
REQ-025 SHALL ignore start while busy=1 or in DONE; it has no effect on the current scan.
REQ-026 SHALL ignore in_valid and in_data outside SCAN.
REQ-027 SHALL, when all samples equal the maximum positive value, end with min_out = maximum positive and min_idx = 0.
REQ-028 SHALL handle the most negative value (1 followed by zeros) as the smallest; it is loaded and never replaced.
REQ-029 SHALL give a latency of 2 cycles from the start edge to in_ready=1, and the done pulse one cycle after the last accepted sample.
REQ-030 SHALL, for a zero-stall scan, produce done exactly COUNT+2 cycles after the start edge.

Reset
REQ-031 SHALL, when rst=0, asynchronously force state=IDLE, min_out=0, min_idx=0, counter=0, done=0, busy=0 and in_ready=0, regardless of clk.
REQ-032 SHALL abort a scan interrupted by reset completely; after rst returns to 1 the block waits in IDLE for a new start, and no done pulse is produced.
REQ-033 SHALL release reset synchronously with respect to next-state updates; the first edge with rst=1 only evaluates the IDLE logic.

Verification
REQ-034 SHALL cover: SIZE=8, COUNT=4, samples 5, -3, 7, -3 with no stalls -> done at start+6 cycles, min_out=-3 (0xFD), min_idx=1.
REQ-035 SHALL cover: samples 127, 127, 127, 127 -> min_out=127, min_idx=0, done pulse width 1 cycle.
REQ-036 SHALL cover: samples 10, -128, 0, -128 with in_valid low for 3 cycles between the 2nd and 3rd samples -> min_out=-128, min_idx=1, done at start+9 cycles.
REQ-037 SHALL cover: start held high during SCAN and DONE -> only one scan is performed, then a new INIT follows IDLE if start is still high.
REQ-038 SHALL cover: rst pulsed low after 2 accepted samples -> all outputs 0 immediately, no done; a fresh scan then gives correct results.
REQ-039 SHALL cover: in_valid=1 while in IDLE or INIT -> samples are not counted (in_ready=0) and the result is unaffected.

Source files
------------

// File: rtl/min_scan_unit.sv
// min_scan_unit: scans COUNT signed samples and reports the smallest one and the
// index where it first appeared. A scan runs IDLE -> INIT -> SCAN -> DONE. Every
// output is taken straight from a flop, so downstream logic sees clean registered
// values.
module min_scan_unit #(
    parameter  int SIZE  = 8,
    parameter  int COUNT = 16,
    localparam int IW    = $clog2(COUNT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic signed [SIZE-1:0] in_data,
    output logic                   in_ready,
    output logic                   busy,
    output logic                   done,
    output logic signed [SIZE-1:0] min_out,
    output logic        [IW-1:0]   min_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

    // The largest positive value seeds the running minimum, so the first sample
    // always replaces it unless that sample is also the largest positive value.
    localparam logic signed [SIZE-1:0] MAX_POS = {1'b0, {(SIZE-1){1'b1}}};
    localparam logic        [IW-1:0]   LAST    = IW'(COUNT - 1);

    state_t                 state_q, state_d;
    logic signed [SIZE-1:0] min_q, min_d;
    logic        [IW-1:0]   idx_q, idx_d;
    logic        [IW-1:0]   cnt_q, cnt_d;
    logic                   in_ready_q, in_ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    // Next-state and next-output logic. The status flags are computed one cycle
    // ahead so that they match the state the FSM is about to enter.
    always_comb begin
        state_d    = state_q;
        min_d      = min_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        in_ready_d = in_ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = INIT;
                    busy_d  = 1'b1;
                end
            end
            INIT: begin
                state_d    = SCAN;
                min_d      = MAX_POS;
                idx_d      = '0;
                cnt_d      = '0;
                in_ready_d = 1'b1;
                busy_d     = 1'b1;
            end
            SCAN: begin
                if (in_valid) begin
                    // A strict less-than keeps the earliest index when minima tie.
                    if (in_data < min_q) begin
                        min_d = in_data;
                        idx_d = cnt_q;
                    end
                    if (cnt_q == LAST) begin
                        state_d    = DONE;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + IW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State register. Reset clears everything at once and abandons any scan in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            min_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            min_q      <= min_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign min_out  = min_q;
    assign min_idx  = idx_q;

endmodule

// File: tb/tb_min_scan_unit.sv
// Testbench for min_scan_unit with SIZE=8 and COUNT=4. A reference model computes
// the expected minimum and its first index from the list of samples.
module tb_min_scan_unit;

   localparam int SIZE  = 8;
   localparam int COUNT = 4;
   localparam int IW    = $clog2(COUNT);

   logic                   clk      = 1'b0;
   logic                   rst      = 1'b0;
   logic                   start    = 1'b0;
   logic                   in_valid = 1'b0;
   logic signed [SIZE-1:0] in_data  = '0;
   logic                   in_ready;
   logic                   busy;
   logic                   done;
   logic signed [SIZE-1:0] min_out;
   logic        [IW-1:0]   min_idx;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   min_scan_unit #(.SIZE(SIZE), .COUNT(COUNT)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .busy     (busy),
      .done     (done),
      .min_out  (min_out),
      .min_idx  (min_idx)
   );

   // Free-running clock with a 10-unit period.
   always #5 clk = ~clk;

   // Count rising edges so that latencies can be measured in cycles.
   always @(posedge clk) cycle <= cycle + 1;

   // Stop a run that hangs, after reporting the hang as a failure.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)",
                tag, $signed(obs), obs, $signed(exp), exp);
      end
   endtask

   // Reference model: find the smallest value, then the first position that holds it.
   function automatic void refMin(input int s[COUNT], output int mv, output int mi);
      mv = s[0];
      foreach (s[i]) if (s[i] < mv) mv = s[i];
      mi = -1;
      foreach (s[i]) if (mi < 0 && s[i] == mv) mi = i;
   endfunction

   // Run one full scan. stl[i] is the number of idle cycles placed before sample i
   // (i >= 1). The task returns at the falling edge of the first IDLE cycle after DONE.
   task automatic applyStimulus(input string name, input int s[COUNT], input int stl[COUNT],
                                input bit holdStart);
      int  c0, expMin, expIdx, expLat;
      bit  ok;
      refMin(s, expMin, expIdx);
      expLat = COUNT + 2;
      for (int i = 1; i < COUNT; i++) expLat += stl[i];

      @(posedge clk); #1;
      start    = 1'b1;
      in_valid = 1'b1;
      in_data  = SIZE'(s[0]);
      c0       = cycle;
      @(posedge clk); #1;
      start = holdStart;
      @(negedge clk);
      checkOutput({name, " busy in INIT"}, 32'(busy), 1);
      checkOutput({name, " in_ready in INIT"}, 32'(in_ready), 0);

      for (int i = 0; i < COUNT; i++) begin
         if (i > 0) begin
            if (stl[i] > 0) begin
               in_valid = 1'b0;
               in_data  = SIZE'($urandom);
               repeat (stl[i]) @(posedge clk);
               #1;
            end
            in_valid = 1'b1;
            in_data  = SIZE'(s[i]);
         end
         ok = 1'b0;
         for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
               @(posedge clk); #1;
               ok = 1'b1;
            end
         end
         if (!ok) begin
            checkOutput({name, " in_ready timeout"}, 32'(in_ready), 1);
            in_valid = 1'b0;
            start    = 1'b0;
            return;
         end
      end

      // Samples presented outside SCAN must be ignored.
      in_valid = 1'b1;
      in_data  = -8'sd128;
      @(negedge clk);
      checkOutput({name, " done"}, 32'(done), 1);
      checkOutput({name, " latency"}, 32'(cycle - c0), expLat);
      checkOutput({name, " min_out"}, 32'(min_out), expMin);
      checkOutput({name, " min_idx"}, 32'(min_idx), expIdx);
      checkOutput({name, " busy in DONE"}, 32'(busy), 0);
      checkOutput({name, " in_ready in DONE"}, 32'(in_ready), 0);
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput({name, " done width"}, 32'(done), 0);
      checkOutput({name, " min_out held"}, 32'(min_out), expMin);
      checkOutput({name, " min_idx held"}, 32'(min_idx), expIdx);
      checkOutput({name, " busy in IDLE"}, 32'(busy), 0);
   endtask

   int smp[COUNT];
   int stl[COUNT];
   bit seenDone;

   // Directed and random scenarios.
   initial begin
      // Reset state while reset is held.
      #2;
      checkOutput("reset min_out", 32'(min_out), 0);
      checkOutput("reset min_idx", 32'(min_idx), 0);
      checkOutput("reset busy", 32'(busy), 0);
      checkOutput("reset done", 32'(done), 0);
      checkOutput("reset in_ready", 32'(in_ready), 0);
      @(negedge clk);
      rst = 1'b1;

      // Basic scan with a tied minimum.
      smp = '{5, -3, 7, -3};
      stl = '{0, 0, 0, 0};
      applyStimulus("basic", smp, stl, 1'b0);

      // All samples equal the largest positive value.
      smp = '{127, 127, 127, 127};
      applyStimulus("allmax", smp, stl, 1'b0);

      // Most negative value with stall cycles.
      smp = '{10, -128, 0, -128};
      stl = '{0, 0, 3, 0};
      applyStimulus("mostneg", smp, stl, 1'b0);

      // in_valid held high while idle must not count samples.
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = -8'sd100;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("idle valid in_ready", 32'(in_ready), 0);
      checkOutput("idle valid busy", 32'(busy), 0);
      smp = '{20, 30, 15, 40};
      stl = '{0, 0, 0, 0};
      applyStimulus("idlevalid", smp, stl, 1'b0);

      // start held high throughout: exactly one scan, then a fresh INIT.
      smp = '{4, 3, 2, 1};
      applyStimulus("holdstart", smp, stl, 1'b1);
      @(negedge clk);
      checkOutput("holdstart restart busy", 32'(busy), 1);
      checkOutput("holdstart restart in_ready", 32'(in_ready), 0);
      start = 1'b0;
      rst   = 1'b0;
      #1;
      checkOutput("holdstart reset busy", 32'(busy), 0);
      @(negedge clk);
      rst = 1'b1;

      // Reset in the middle of a scan after two samples have been accepted.
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("abort in_ready", 32'(in_ready), 1);
      in_valid = 1'b1;
      in_data  = -8'sd100;
      @(posedge clk); #1;
      in_data  = -8'sd50;
      @(posedge clk); #1;
      in_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      checkOutput("abort min_out", 32'(min_out), 0);
      checkOutput("abort min_idx", 32'(min_idx), 0);
      checkOutput("abort busy", 32'(busy), 0);
      checkOutput("abort in_ready cleared", 32'(in_ready), 0);
      checkOutput("abort done", 32'(done), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      seenDone = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) seenDone = 1'b1;
      end
      checkOutput("abort stays idle", 32'(seenDone), 0);
      smp = '{-1, -7, 3, -7};
      applyStimulus("afterabort", smp, stl, 1'b0);

      // Random scans with random stalls, biased towards extremes and ties.
      for (int n = 0; n < 20; n++) begin
         for (int i = 0; i < COUNT; i++) begin
            case ($urandom_range(0, 5))
               0:       smp[i] = -128;
               1:       smp[i] = 127;
               2:       smp[i] = int'($urandom_range(0, 3)) - 2;
               default: smp[i] = int'($urandom_range(0, 255)) - 128;
            endcase
            stl[i] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
         end
         applyStimulus("random", smp, stl, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
